// File: rtl/vending_change_dispenser.sv
// Change payout engine: takes a nickel count over valid/ready and emits one-cycle
// dime/nickel eject pulses, preferring dimes unless the dime tube reports empty.
module vending_change_dispenser #(
    parameter int AMOUNT_W = 5,
    parameter int GAP      = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [AMOUNT_W-1:0] req_amount,
    input  logic                dime_empty,
    output logic                nickel,
    output logic                dime,
    output logic                done,
    output logic                busy
);

    localparam int GAP_W = (GAP < 1) ? 1 : $clog2(GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [AMOUNT_W-1:0] remaining;
    logic [GAP_W-1:0]    gap_cnt;
    logic                coin_dime;

    logic [AMOUNT_W-1:0] decision_base;
    logic [AMOUNT_W-1:0] decision_next;
    logic                take_dime;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; S_GAP is unreachable when GAP is zero
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    next_state = (req_amount == '0) ? S_DONE : S_EMIT;
                end
            end
            S_EMIT: begin
                if (remaining == '0) begin
                    next_state = S_DONE;
                end else if (GAP == 0) begin
                    next_state = S_EMIT;
                end else begin
                    next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(1)) begin
                    next_state = S_EMIT;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Coin decision for whichever edge enters EMIT; a fresh request decides on req_amount
    always_comb begin
        decision_base = (state == S_IDLE) ? req_amount : remaining;
        take_dime     = (decision_base >= AMOUNT_W'(2)) && !dime_empty;
        decision_next = decision_base - (take_dime ? AMOUNT_W'(2) : AMOUNT_W'(1));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= '0;
            coin_dime <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            if (next_state == S_EMIT) begin
                remaining <= decision_next;
                coin_dime <= take_dime;
            end
            if (state == S_EMIT && next_state == S_GAP) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    // Outputs decode only registered state, so reset clears them without waiting for an edge
    always_comb begin
        req_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        nickel    = (state == S_EMIT) && !coin_dime;
        dime      = (state == S_EMIT) && coin_dime;
    end

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Directed bench for vending_change_dispenser (GAP=2, AMOUNT_W=5); per-cycle pulse
// masks are captured relative to the handshake and compared to hand-derived values.
module tb_vending_change_dispenser;

    logic       clock;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_amount;
    logic       dime_empty;
    logic       nickel;
    logic       dime;
    logic       done;
    logic       busy;

    int checks;
    int failures;

    logic [63:0] nick_log;
    logic [63:0] dime_log;
    logic [63:0] done_log;
    logic [63:0] ready_log;
    logic [63:0] busy_log;
    logic [63:0] clash_log;
    logic [63:0] exp_dimes;

    vending_change_dispenser #(
        .AMOUNT_W(5),
        .GAP     (2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_amount(req_amount),
        .dime_empty(dime_empty),
        .nickel    (nickel),
        .dime      (dime),
        .done      (done),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Handshake happens on the first edge; bit c of each log holds cycle c (sampled #1 after edge)
    task automatic applyStimulus(input logic [4:0] amount, input int ncycles, input logic hold_valid,
                                 input int de_cycle, input logic de_value, input int rst_cycle);
        nick_log  = '0;
        dime_log  = '0;
        done_log  = '0;
        ready_log = '0;
        busy_log  = '0;
        clash_log = '0;
        @(negedge clock);
        req_amount = amount;
        req_valid  = 1'b1;
        checkOutput("ready_before_handshake", {63'd0, req_ready}, 64'd1);
        for (int c = 1; c <= ncycles; c++) begin
            @(posedge clock);
            #1;
            if (c == 1 && !hold_valid) req_valid = 1'b0;
            nick_log[c]  = nickel;
            dime_log[c]  = dime;
            done_log[c]  = done;
            ready_log[c] = req_ready;
            busy_log[c]  = busy;
            clash_log[c] = (nickel && dime) || ((nickel || dime) && done);
            if (c == ncycles) req_valid = 1'b0;
            if (c == de_cycle) dime_empty = de_value;
            if (c == rst_cycle) begin
                #1 reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_amount = '0;
        dime_empty = 1'b0;
        #1;
        checkOutput("reset_outputs", {59'd0, nickel, dime, done, busy, req_ready}, 64'h1);
        #12 reset_n = 1'b1;

        // Test 1: async reset mid-payout clears outputs before the next edge
        applyStimulus(5'd3, 1, 1'b0, 0, 1'b0, 0);
        checkOutput("t1_dime_before_reset", dime_log, 64'h2);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t1_async_reset_outputs", {59'd0, nickel, dime, done, busy, req_ready}, 64'h1);
        #1 reset_n = 1'b1;

        // Test 2: amount 3 -> dime@1, nickel@4, done@5, ready@6
        applyStimulus(5'd3, 6, 1'b0, 0, 1'b0, 0);
        checkOutput("t2_dime", dime_log, 64'h2);
        checkOutput("t2_nickel", nick_log, 64'h10);
        checkOutput("t2_done", done_log, 64'h20);
        checkOutput("t2_ready", ready_log, 64'h40);
        checkOutput("t2_busy", busy_log, 64'h3E);
        checkOutput("t2_clash", clash_log, 64'h0);

        // Test 3: amount 4 with dime tube empty -> four nickels
        dime_empty = 1'b1;
        applyStimulus(5'd4, 12, 1'b0, 0, 1'b0, 0);
        checkOutput("t3_dime", dime_log, 64'h0);
        checkOutput("t3_nickel", nick_log, 64'h492);
        checkOutput("t3_done", done_log, 64'h800);
        checkOutput("t3_ready", ready_log, 64'h1000);
        dime_empty = 1'b0;

        // Test 4: amount 0 -> done@1, ready@2
        applyStimulus(5'd0, 2, 1'b0, 0, 1'b0, 0);
        checkOutput("t4_coins", nick_log | dime_log, 64'h0);
        checkOutput("t4_done", done_log, 64'h2);
        checkOutput("t4_ready", ready_log, 64'h4);

        // Test 5: dime tube empties after the first coin
        applyStimulus(5'd4, 9, 1'b0, 1, 1'b1, 0);
        checkOutput("t5_dime", dime_log, 64'h2);
        checkOutput("t5_nickel", nick_log, 64'h90);
        checkOutput("t5_done", done_log, 64'h100);
        checkOutput("t5_ready", ready_log, 64'h200);
        checkOutput("t5_clash", clash_log, 64'h0);
        dime_empty = 1'b0;

        // Test 6: reset during cycle 2 abandons the payout; a new request works normally
        applyStimulus(5'd6, 10, 1'b0, 0, 1'b0, 2);
        checkOutput("t6_dime", dime_log, 64'h2);
        checkOutput("t6_nickel", nick_log, 64'h0);
        checkOutput("t6_done", done_log, 64'h0);
        checkOutput("t6_ready", ready_log, 64'h7F8);
        applyStimulus(5'd2, 3, 1'b0, 0, 1'b0, 0);
        checkOutput("t6b_dime", dime_log, 64'h2);
        checkOutput("t6b_nickel", nick_log, 64'h0);
        checkOutput("t6b_done", done_log, 64'h4);
        checkOutput("t6b_ready", ready_log, 64'h8);

        // Test 7: maximum amount with req_valid held high throughout
        exp_dimes = '0;
        for (int k = 0; k < 15; k++) exp_dimes[1 + 3 * k] = 1'b1;
        applyStimulus(5'd31, 48, 1'b1, 0, 1'b0, 0);
        checkOutput("t7_dime", dime_log, exp_dimes);
        checkOutput("t7_nickel", nick_log, 64'h1 << 46);
        checkOutput("t7_done", done_log, 64'h1 << 47);
        checkOutput("t7_ready", ready_log, 64'h1 << 48);
        checkOutput("t7_clash", clash_log, 64'h0);

        repeat (2) @(posedge clock);
        #1;
        checkOutput("final_idle", {59'd0, nickel, dime, done, busy, req_ready}, 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
